// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, mispredict flush,
// and a data-cache miss wait machine with sticky timeout and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs1_if,
  input  logic [4:0]       rs2_if,
  input  logic             uses_rs2_if,
  input  logic             mem_access,
  input  logic             cache_hit,
  input  logic             refill_done,
  input  logic             mispredict,
  output logic             en_pc,
  output logic             en_if,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             rst_if,
  output logic             rst_ex,
  output logic             rst_mem,
  output logic             refill_req,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MISS_WAIT, MISS_REPLAY} state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              hazard, miss, wait_limit, flush_acc;

  assign hazard = memread_ex && (rd_ex != 5'd0) &&
                  ((rd_ex == rs1_if) || (uses_rs2_if && (rd_ex == rs2_if)));
  assign miss   = mem_access && !cache_hit;

  assign wait_limit  = (state == MISS_WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  // Visible in the very cycle the limit is reached, then held by timeout_q.
  assign timeout_err = timeout_q || wait_limit;

  always_comb begin
    state_nxt  = state;
    en_pc      = 1'b0;
    en_if      = 1'b0;
    en_ex      = 1'b0;
    en_mem     = 1'b0;
    en_wb      = 1'b0;
    rst_if     = 1'b0;
    rst_ex     = 1'b0;
    rst_mem    = 1'b0;
    refill_req = 1'b0;
    flush_acc  = 1'b0;
    case (state)
      RUN: begin
        if (miss) begin
          // Whole pipe freezes; a pending mispredict stays in EX until resume.
          state_nxt = MISS_WAIT;
        end else if (mispredict) begin
          {en_pc, en_if, en_ex, en_mem, en_wb} = 5'b11111;
          rst_if    = 1'b1;
          rst_ex    = 1'b1;
          flush_acc = 1'b1;
        end else if (hazard) begin
          {en_ex, en_mem, en_wb} = 3'b111;
          rst_ex = 1'b1;
        end else begin
          {en_pc, en_if, en_ex, en_mem, en_wb} = 5'b11111;
        end
      end
      MISS_WAIT: begin
        refill_req = 1'b1;
        if (refill_done) state_nxt = MISS_REPLAY;
      end
      MISS_REPLAY: state_nxt = RUN;
      default:     state_nxt = RUN;
    endcase
    if (rst) begin
      {en_pc, en_if, en_ex, en_mem, en_wb} = 5'b00000;
      {rst_if, rst_ex, rst_mem}           = 3'b111;
      refill_req = 1'b0;
      flush_acc  = 1'b0;
      state_nxt  = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == MISS_WAIT && !refill_done) begin
        if (!wait_limit) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (wait_limit) timeout_q <= 1'b1;
      if (!en_pc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_acc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus hand sequences
// for cache miss/refill, timeout and reset during a miss.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_ex;
  logic [4:0]  rd_ex, rs1_if, rs2_if;
  logic        uses_rs2_if, mem_access, cache_hit, refill_done, mispredict;
  logic        en_pc, en_if, en_ex, en_mem, en_wb;
  logic        rst_if, rst_ex, rst_mem;
  logic        refill_req, timeout_err;
  logic [15:0] stall_cnt, flush_cnt;

  int n_pass = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs1_if(rs1_if), .rs2_if(rs2_if),
    .uses_rs2_if(uses_rs2_if), .mem_access(mem_access), .cache_hit(cache_hit),
    .refill_done(refill_done), .mispredict(mispredict),
    .en_pc(en_pc), .en_if(en_if), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
    .rst_if(rst_if), .rst_ex(rst_ex), .rst_mem(rst_mem),
    .refill_req(refill_req), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       memread;
    logic [4:0] rd, rs1, rs2;
    logic       uses_rs2, mem_acc, hit, mispred;
    logic [4:0] exp_en;     // {pc, if, ex, mem, wb}
    logic [2:0] exp_flush;  // {if, ex, mem}
  } vec_t;

  vec_t vecs[10];

  function automatic logic [4:0] en_bus();
    return {en_pc, en_if, en_ex, en_mem, en_wb};
  endfunction

  function automatic logic [2:0] flush_bus();
    return {rst_if, rst_ex, rst_mem};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle();
    memread_ex = 1'b0; rd_ex = 5'd0; rs1_if = 5'd0; rs2_if = 5'd0;
    uses_rs2_if = 1'b0; mem_access = 1'b0; cache_hit = 1'b1;
    refill_done = 1'b0; mispredict = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b000};
    vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00111, 3'b010};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b000};
    vecs[3] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b000};
    vecs[4] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00111, 3'b010};
    vecs[5] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b000};
    vecs[6] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b110};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 3'b110};
    vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b000};
    vecs[9] = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00111, 3'b010};

    // Reset state
    rst = 1'b1;
    idle();
    #7;
    chk("rst_en", 32'(en_bus()), 32'h00);
    chk("rst_flush", 32'(flush_bus()), 32'h7);
    chk("rst_refill_req", 32'(refill_req), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // RUN-state vector table
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      memread_ex  = vecs[i].memread;
      rd_ex       = vecs[i].rd;
      rs1_if      = vecs[i].rs1;
      rs2_if      = vecs[i].rs2;
      uses_rs2_if = vecs[i].uses_rs2;
      mem_access  = vecs[i].mem_acc;
      cache_hit   = vecs[i].hit;
      mispredict  = vecs[i].mispred;
      #2;
      chk($sformatf("vec%0d_en", i), 32'(en_bus()), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_flush", i), 32'(flush_bus()), 32'(vecs[i].exp_flush));
      chk($sformatf("vec%0d_refill_req", i), 32'(refill_req), 32'h0);
      if (!vecs[i].exp_en[4]) exp_stall++;
      if (vecs[i].exp_flush[2]) exp_flush++;
    end
    @(negedge clk);
    idle();
    #2;
    chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // Miss with refill after 5 wait cycles; mispredict held across the miss
    reset_dut();
    @(negedge clk);
    mem_access = 1'b1; cache_hit = 1'b0; mispredict = 1'b1;
    #2;
    chk("miss_run_en", 32'(en_bus()), 32'h00);
    chk("miss_run_flush", 32'(flush_bus()), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) refill_done = 1'b1;
      #2;
      chk($sformatf("wait%0d_refill_req", k), 32'(refill_req), 32'h1);
      chk($sformatf("wait%0d_en", k), 32'(en_bus()), 32'h00);
    end
    @(negedge clk);
    refill_done = 1'b0;
    #2;
    chk("replay_refill_req", 32'(refill_req), 32'h0);
    chk("replay_en", 32'(en_bus()), 32'h00);
    @(negedge clk);
    cache_hit = 1'b1;
    #2;
    chk("resume_en", 32'(en_bus()), 32'h1f);
    chk("resume_flush", 32'(flush_bus()), 32'h6);
    @(negedge clk);
    idle();
    #2;
    chk("miss_stall_cnt", 32'(stall_cnt), 32'd7);
    chk("miss_flush_cnt", 32'(flush_cnt), 32'd1);

    // Timeout: no refill for 64+ wait cycles, then reset clears it
    reset_dut();
    @(negedge clk);
    mem_access = 1'b1; cache_hit = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      #2;
      if (c == 63 || c >= 64)
        chk($sformatf("timeout_c%0d", c), 32'(timeout_err), 32'(c >= 64));
      if (c == 67) chk("timeout_still_waiting", 32'(refill_req), 32'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    #2;
    chk("timeout_cleared", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-miss
    @(negedge clk);
    mispredict = 1'b1;
    @(negedge clk);
    mispredict = 1'b0; mem_access = 1'b1; cache_hit = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("mid_refill_req", 32'(refill_req), 32'h1);
    chk("mid_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("mid_flush_cnt", 32'(flush_cnt), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_refill_req", 32'(refill_req), 32'h0);
    chk("async_en", 32'(en_bus()), 32'h00);
    chk("async_flush", 32'(flush_bus()), 32'h7);
    chk("async_stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    chk("post_rst_en", 32'(en_bus()), 32'h1f);
    chk("post_rst_refill_req", 32'(refill_req), 32'h0);
    chk("post_rst_flush_cnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    #2;
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
